// File: rtl/sys_array_collector.sv
// Collects the skewed per-column output stream of a systolic array into a
// square result matrix and presents it on a valid/ready output register.
`timescale 1ns/1ps

module sys_array_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W    = 4
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  start,
    input  logic [0:ARRAY_W-1][2*DATA_WIDTH-1:0]                  in_data,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0]     out_data,
    output logic                                                  busy,
    output logic                                                  drop_err
);

    localparam int RW = 2 * DATA_WIDTH;
    localparam int KW = $clog2(2 * ARRAY_W);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_LAST = KW'(2 * ARRAY_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    typedef logic [0:ARRAY_W-1][0:ARRAY_W-1][RW-1:0] matrix_t;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    matrix_t         bank_q;
    matrix_t         bank_d;
    matrix_t         out_data_q;
    logic            out_valid_q;
    logic            busy_q;
    logic            drop_err_q;
    logic            handshake;

    assign handshake = out_valid_q && out_ready;

    // In capture cycle k, column c carries row k-1-c; every other column is skew padding.
    always_comb begin
        // NOTE: full default first so no path leaves bank_d unassigned (no latch).
        bank_d = bank_q;
        if (state_q == ST_CAPTURE) begin
            for (int r = 0; r < ARRAY_W; r++) begin
                for (int c = 0; c < ARRAY_W; c++) begin
                    if (r + c + 1 == int'(k_q)) begin
                        bank_d[r][c] = in_data[c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            // NOTE: the bank is cleared on reset so no stale partial result survives it.
            bank_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            drop_err_q <= 1'b0;
            bank_q     <= bank_d;
            if (handshake) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_CAPTURE;
                        k_q     <= K_ONE;
                        busy_q  <= 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    if (start) begin
                        drop_err_q <= 1'b1;
                    end
                    if (k_q == K_LAST) begin
                        // Hand over directly when the output register is free this cycle.
                        if (!out_valid_q || out_ready) begin
                            out_data_q  <= bank_d;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_IDLE;
                            k_q         <= '0;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end else begin
                        k_q <= k_q + K_ONE;
                    end
                end

                ST_HOLD: begin
                    if (start) begin
                        drop_err_q <= 1'b1;
                    end
                    if (handshake) begin
                        out_data_q  <= bank_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        k_q         <= '0;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    k_q     <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_sys_array_collector.sv
// Self-checking bench for sys_array_collector: table of streams plus directed
// hold, drop and abort sequences, with a scoreboard on the output handshake.
`timescale 1ns/1ps

module tb_sys_array_collector;

    localparam int W  = 4;
    localparam int DW = 8;
    localparam int RW = 2 * DW;

    typedef logic [0:W-1][0:W-1][RW-1:0] matrix_t;

    typedef struct {
        logic [RW-1:0] base;
        logic [RW-1:0] sr;
        logic [RW-1:0] sc;
        bit            garb;
        logic [RW-1:0] exp00;
        logic [RW-1:0] exp33;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [0:W-1][RW-1:0]  in_data;
    logic                  out_valid;
    logic                  out_ready;
    matrix_t               out_data;
    logic                  busy;
    logic                  drop_err;

    int      errors = 0;
    int      checks = 0;
    matrix_t sb[$];
    matrix_t mon_exp;
    vec_t    vecs[4];
    logic    seen;

    sys_array_collector #(
        .DATA_WIDTH(DW),
        .ARRAY_W   (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    task automatic checkb(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkm(input string name, input matrix_t got, input matrix_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] elem(input logic [RW-1:0] base, input logic [RW-1:0] sr,
                                           input logic [RW-1:0] sc, input int r, input int c);
        return base + sr * RW'(r) + sc * RW'(c);
    endfunction

    // Drive the skewed column values for capture cycle k; off-diagonal lanes carry filler.
    task automatic drive_in(input logic [RW-1:0] base, input logic [RW-1:0] sr,
                            input logic [RW-1:0] sc, input bit garb, input int k);
        for (int c = 0; c < W; c++) begin
            int r = k - 1 - c;
            if (r >= 0 && r < W) in_data[c] = elem(base, sr, sc, r, c);
            else                 in_data[c] = garb ? 16'hFFFF : 16'h0000;
        end
    endtask

    // Runs cycles 0..7 of one stream and returns at cycle 8.
    task automatic run_stream(input logic [RW-1:0] base, input logic [RW-1:0] sr,
                              input logic [RW-1:0] sc, input bit garb, input bit free,
                              input int extra_k, input int ready_k);
        matrix_t m;
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                m[r][c] = elem(base, sr, sc, r, c);
        sb.push_back(m);
        for (int k = 0; k < 2 * W; k++) begin
            start = (k == 0) || (k == extra_k);
            if (k == ready_k) out_ready = 1'b1;
            drive_in(base, sr, sc, garb, k);
            tick();
            if (k < 2 * W - 1) checkb("cap_busy", busy, 1'b1);
            checkb("cap_drop", drop_err, (k == extra_k) && (k != 0));
            if (free && k >= 1 && k < 2 * W - 1) checkb("cap_no_valid", out_valid, 1'b0);
        end
        start   = 1'b0;
        in_data = '0;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checkb("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                checkm("sb_matrix", out_data, mon_exp);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;

        vecs[0] = '{16'd0,    16'd10,   16'd1,    1'b0, 16'd0,    16'd33};
        vecs[1] = '{16'hFFF0, 16'h0100, 16'h0001, 1'b0, 16'hFFF0, 16'h02F3};
        vecs[2] = '{16'h8000, 16'h1111, 16'h0202, 1'b1, 16'h8000, 16'hB939};
        vecs[3] = '{16'hA5A5, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 16'hA5A5};

        repeat (2) tick();
        checkb("rst_valid", out_valid, 1'b0);
        checkb("rst_busy", busy, 1'b0);
        checkb("rst_drop", drop_err, 1'b0);
        checkm("rst_data", out_data, '0);
        reset = 1'b0;
        tick();

        // Back-to-back streams at full throughput.
        for (int i = 0; i < 4; i++) begin
            run_stream(vecs[i].base, vecs[i].sr, vecs[i].sc, vecs[i].garb, 1'b1, -1, -1);
            checkb("b2b_valid", out_valid, 1'b1);
            checkb("b2b_busy", busy, 1'b0);
            checkw("b2b_d00", out_data[0][0], vecs[i].exp00);
            checkw("b2b_d33", out_data[3][3], vecs[i].exp33);
        end

        // Second start at cycle 3 is dropped.
        run_stream(vecs[1].base, vecs[1].sr, vecs[1].sc, 1'b0, 1'b1, 3, -1);
        checkb("drop_valid", out_valid, 1'b1);
        checkw("drop_d33", out_data[3][3], vecs[1].exp33);
        tick();
        checkb("drop_drained", out_valid, 1'b0);

        // Stalled output: A presented, B parked in HOLD.
        out_ready = 1'b0;
        run_stream(vecs[0].base, vecs[0].sr, vecs[0].sc, 1'b0, 1'b1, -1, -1);
        checkb("holdA_valid", out_valid, 1'b1);
        checkw("holdA_d33", out_data[3][3], vecs[0].exp33);
        run_stream(vecs[1].base, vecs[1].sr, vecs[1].sc, 1'b0, 1'b0, -1, -1);
        checkb("hold_busy", busy, 1'b1);
        checkb("hold_valid", out_valid, 1'b1);
        checkw("hold_stable", out_data[3][3], vecs[0].exp33);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkb("hold_drop", drop_err, 1'b1);
        checkb("hold_busy2", busy, 1'b1);
        checkw("hold_stable2", out_data[3][3], vecs[0].exp33);
        tick();
        checkb("hold_drop_pulse", drop_err, 1'b0);
        out_ready = 1'b1;
        tick();
        checkb("holdB_valid", out_valid, 1'b1);
        checkb("holdB_busy", busy, 1'b0);
        checkw("holdB_d33", out_data[3][3], vecs[1].exp33);
        tick();
        checkb("holdB_drained", out_valid, 1'b0);

        // Output accepted in the very cycle the next stream completes.
        out_ready = 1'b0;
        run_stream(vecs[2].base, vecs[2].sr, vecs[2].sc, 1'b1, 1'b1, -1, -1);
        checkw("edgeC_d33", out_data[3][3], vecs[2].exp33);
        run_stream(vecs[3].base, vecs[3].sr, vecs[3].sc, 1'b1, 1'b0, -1, 7);
        checkb("edgeD_busy", busy, 1'b0);
        checkb("edgeD_valid", out_valid, 1'b1);
        checkw("edgeD_d33", out_data[3][3], vecs[3].exp33);
        tick();
        checkb("edgeD_drained", out_valid, 1'b0);

        // Reset at cycle 4 of a capture, together with a start.
        start = 1'b1;
        drive_in(vecs[1].base, vecs[1].sr, vecs[1].sc, 1'b0, 0);
        tick();
        start = 1'b0;
        for (int k = 1; k < 4; k++) begin
            drive_in(vecs[1].base, vecs[1].sr, vecs[1].sc, 1'b0, k);
            tick();
        end
        drive_in(vecs[1].base, vecs[1].sr, vecs[1].sc, 1'b0, 4);
        reset = 1'b1;
        start = 1'b1;
        tick();
        checkb("abort_busy", busy, 1'b0);
        checkb("abort_valid", out_valid, 1'b0);
        checkb("abort_drop", drop_err, 1'b0);
        checkm("abort_data", out_data, '0);
        reset   = 1'b0;
        start   = 1'b0;
        in_data = '0;
        seen    = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | out_valid;
        end
        checkb("abort_no_valid", seen, 1'b0);
        run_stream(vecs[2].base, vecs[2].sr, vecs[2].sc, 1'b1, 1'b1, -1, -1);
        checkb("after_abort_valid", out_valid, 1'b1);
        checkw("after_abort_d00", out_data[0][0], vecs[2].exp00);
        tick();

        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        checkb("sb_drained", sb.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
